dadd_acc_pipe: RTL and testbench

- Parametrised successor to the single-channel dadd datapath: an address-indexed signed accumulator bank.
- Each accepted sample (addr, data, op) either adds into or loads accumulator entry [addr].
- The updated value is emitted with its address after a fixed 3-cycle pipeline.
- Sits between the dadd_loc_interface driver side and downstream consumers, and adds saturation, overflow flagging and global clear.

---
 rtl/dadd_acc_pipe.sv | 142 ++++++++++++++
 tb/tb_dadd_acc_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadd_acc_pipe.sv
// dadd_acc_pipe: address-indexed signed accumulator bank with saturation,
// overflow flagging and a global clear. Every accepted sample either adds into
// or overwrites entry [addr]. The updated value appears with its address three
// cycles after the sample is presented.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   dadd_in_en        sample valid (one sample per cycle, never stalled)
//   dadd_in_op        0 = accumulate, 1 = load
//   dadd_in_addr      accumulator index
//   dadd_in           signed sample
//   dadd_clr          synchronous clear of the bank and every in-flight sample
//   dadd_out_en       result valid, one pulse per accepted sample
//   dadd_out_addr     index of the result
//   dadd_out          updated (saturated or wrapped) accumulator value
//   dadd_out_ovf      overflow occurred on this update
module dadd_acc_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 24,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dadd_in_en,
  input  logic                     dadd_in_op,
  input  logic [ADDR_W-1:0]        dadd_in_addr,
  input  logic signed [DATA_W-1:0] dadd_in,
  input  logic                     dadd_clr,
  output logic                     dadd_out_en,
  output logic [ADDR_W-1:0]        dadd_out_addr,
  output logic signed [ACC_W-1:0]  dadd_out,
  output logic                     dadd_out_ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic signed [ACC_W-1:0] bank [DEPTH];

  // S1: registered input sample
  logic                     s1_vld;
  logic                     s1_op;
  logic [ADDR_W-1:0]        s1_addr;
  logic signed [DATA_W-1:0] s1_data;

  // S2: sample (already sign-extended) plus the accumulator operand
  logic                     s2_vld;
  logic                     s2_op;
  logic [ADDR_W-1:0]        s2_addr;
  logic signed [ACC_W-1:0]  s2_ext;
  logic signed [ACC_W-1:0]  s2_acc;

  // S3 result, computed combinationally from S2
  logic signed [ACC_W:0]    sum;
  logic                     add_ovf;
  logic signed [ACC_W-1:0]  res;
  logic                     res_ovf;
  logic signed [ACC_W-1:0]  s2_acc_nxt;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One extra bit of headroom; overflow is judged on the ACC_W-bit signs.
  assign sum     = {s2_acc[ACC_W-1], s2_acc} + {s2_ext[ACC_W-1], s2_ext};
  assign add_ovf = (s2_acc[ACC_W-1] == s2_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != s2_acc[ACC_W-1]);

  always_comb begin
    res     = s2_ext;
    res_ovf = 1'b0;
    if (!s2_op) begin
      res = sum[ACC_W-1:0];
      if (add_ovf) begin
        res_ovf = 1'b1;
        if (SAT_EN) res = s2_acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  // The result is written back to the bank on the same edge that S2 is
  // loaded, so a same-address sample sitting in S1 takes the fresh result
  // instead of the stale bank entry. Anything further behind reads the bank
  // after the write has landed, so this single bypass keeps strict program
  // order for any mix of back-to-back same-address samples.
  assign s2_acc_nxt = (s2_vld && (s2_addr == s1_addr)) ? res : bank[s1_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_op   <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
      s2_vld  <= 1'b0;
      s2_op   <= 1'b0;
      s2_addr <= '0;
      s2_ext  <= '0;
      s2_acc  <= '0;
    end else begin
      s1_vld <= dadd_in_en && !dadd_clr;
      if (dadd_in_en) begin
        s1_op   <= dadd_in_op;
        s1_addr <= dadd_in_addr;
        s1_data <= dadd_in;
      end
      s2_vld <= s1_vld && !dadd_clr;
      if (s1_vld) begin
        s2_op   <= s1_op;
        s2_addr <= s1_addr;
        s2_ext  <= ACC_W'(s1_data);
        s2_acc  <= s2_acc_nxt;
      end
    end
  end

  // Output register: data fields hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dadd_out_en   <= 1'b0;
      dadd_out_addr <= '0;
      dadd_out      <= '0;
      dadd_out_ovf  <= 1'b0;
    end else begin
      dadd_out_en <= s2_vld && !dadd_clr;
      if (s2_vld && !dadd_clr) begin
        dadd_out_addr <= s2_addr;
        dadd_out      <= res;
        dadd_out_ovf  <= res_ovf;
      end
    end
  end

  // Bank write-back; clear wins over the write of the sample being dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (dadd_clr) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (s2_vld) begin
      bank[s2_addr] <= res;
    end
  end

endmodule

// File: tb/tb_dadd_acc_pipe.sv
// Bench for dadd_acc_pipe: three instances share one stimulus stream
// (ACC_W=24 saturating, ACC_W=18 saturating, ACC_W=18 wrapping) and every
// result is compared cycle-exactly against a program-order arithmetic model.
module tb_dadd_acc_pipe;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [63:0] val;
    logic        ovf;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic op = 1'b0;
  logic clr = 1'b0;
  logic [3:0] addr = '0;
  logic signed [15:0] din = '0;

  logic oe [3];
  logic [3:0] oa [3];
  logic ovf [3];
  logic signed [23:0] o0;
  logic signed [17:0] o1, o2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  longint m [3][16];
  rec_t obs [3][$];
  rec_t exq [3][$];

  always #5 clk = ~clk;

  dadd_acc_pipe #(.DATA_W(16), .ADDR_W(4), .ACC_W(24), .SAT_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(en), .dadd_in_op(op), .dadd_in_addr(addr),
    .dadd_in(din), .dadd_clr(clr), .dadd_out_en(oe[0]), .dadd_out_addr(oa[0]),
    .dadd_out(o0), .dadd_out_ovf(ovf[0]));
  dadd_acc_pipe #(.DATA_W(16), .ADDR_W(4), .ACC_W(18), .SAT_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(en), .dadd_in_op(op), .dadd_in_addr(addr),
    .dadd_in(din), .dadd_clr(clr), .dadd_out_en(oe[1]), .dadd_out_addr(oa[1]),
    .dadd_out(o1), .dadd_out_ovf(ovf[1]));
  dadd_acc_pipe #(.DATA_W(16), .ADDR_W(4), .ACC_W(18), .SAT_EN(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .dadd_in_en(en), .dadd_in_op(op), .dadd_in_addr(addr),
    .dadd_in(din), .dadd_clr(clr), .dadd_out_en(oe[2]), .dadd_out_addr(oa[2]),
    .dadd_out(o2), .dadd_out_ovf(ovf[2]));

  // Advance one clock, sample #1 after the edge and log every valid result.
  task automatic tick();
    rec_t r;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (oe[i] === 1'b1) begin
        r.cyc  = cyc;
        r.addr = 32'(oa[i]);
        r.val  = (i == 0) ? longint'(o0) : ((i == 1) ? longint'(o1) : longint'(o2));
        r.ovf  = ovf[i];
        obs[i].push_back(r);
      end
    end
  endtask

  // Reference: plain integer arithmetic in program order, result due 3 cycles on.
  task automatic mdl(input int i, input bit ld, input int a, input int d);
    int     w;
    longint mx, mn, s;
    bit     of;
    rec_t   r;
    w  = (i == 0) ? 24 : 18;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(mx + 1);
    of = 1'b0;
    s  = ld ? longint'(d) : m[i][a] + longint'(d);
    if (s > mx) begin
      of = 1'b1;
      s  = (i == 2) ? s - (longint'(1) << w) : mx;
    end else if (s < mn) begin
      of = 1'b1;
      s  = (i == 2) ? s + (longint'(1) << w) : mn;
    end
    m[i][a] = s;
    r.cyc = cyc + 3; r.addr = a; r.val = s; r.ovf = of;
    exq[i].push_back(r);
  endtask

  task automatic send(input bit ld, input int a, input int d);
    en = 1'b1; op = ld; addr = a[3:0]; din = d[15:0];
    for (int i = 0; i < 3; i++) mdl(i, ld, a, d);
    tick();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic zero_model();
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 16; a++) m[i][a] = 0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({oe[0], oe[1], oe[2], ovf[0], ovf[1], ovf[2]} !== 6'b0 || o0 !== 24'sd0 ||
          o1 !== 18'sd0 || o2 !== 18'sd0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got en=%b%b%b out=%0d/%0d/%0d ovf=%b%b%b, want all 0",
                 cyc, oe[0], oe[1], oe[2], o0, o1, o2, ovf[0], ovf[1], ovf[2]);
      end
    end
  endtask

  task automatic test_forwarding();
    send(0, 3, 5); send(0, 3, 7); send(0, 3, -2);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL fwd_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL fwd inst%0d #%0d: got cyc=%0d addr=%0d val=%0d ovf=%b want cyc=%0d addr=%0d val=%0d ovf=%b",
                   i, k, obs[i][k].cyc, obs[i][k].addr, $signed(obs[i][k].val), obs[i][k].ovf,
                   exq[i][k].cyc, exq[i][k].addr, $signed(exq[i][k].val), exq[i][k].ovf);
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  task automatic test_interleave();
    send(0, 1, 100); send(0, 2, 50); send(0, 1, 1); send(1, 2, -8); send(0, 2, 3);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL ilv_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL ilv inst%0d #%0d: got cyc=%0d addr=%0d val=%0d ovf=%b want cyc=%0d addr=%0d val=%0d ovf=%b",
                   i, k, obs[i][k].cyc, obs[i][k].addr, $signed(obs[i][k].val), obs[i][k].ovf,
                   exq[i][k].cyc, exq[i][k].addr, $signed(exq[i][k].val), exq[i][k].ovf);
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  task automatic test_saturation();
    send(1, 0, 32767);
    for (int k = 0; k < 4; k++) send(0, 0, 32767);
    idle(4);
    // Independent anchors for the final update of the 18-bit instances.
    checks++;
    if (obs[1].size() != 5) begin
      errors++; $display("FAIL sat_final_count: got %0d want 5", obs[1].size());
    end else if ($signed(obs[1][4].val) != 131071 || obs[1][4].ovf !== 1'b1 || obs[1][3].ovf !== 1'b0) begin
      errors++; $display("FAIL sat_final: got %0d ovf=%b want 131071 ovf=1", $signed(obs[1][4].val), obs[1][4].ovf);
    end
    checks++;
    if (obs[2].size() != 5) begin
      errors++; $display("FAIL wrap_final_count: got %0d want 5", obs[2].size());
    end else if ($signed(obs[2][4].val) != -98309 || obs[2][4].ovf !== 1'b1) begin
      errors++; $display("FAIL wrap_final: got %0d ovf=%b want -98309 ovf=1", $signed(obs[2][4].val), obs[2][4].ovf);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL sat_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL sat inst%0d #%0d: got val=%0d ovf=%b want val=%0d ovf=%b",
                   i, k, $signed(obs[i][k].val), obs[i][k].ovf, $signed(exq[i][k].val), exq[i][k].ovf);
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  task automatic test_clear();
    send(0, 0, 1); send(0, 1, 2);
    // Same-cycle sample with clear: nothing in flight may emerge.
    en = 1'b1; op = 1'b0; addr = 4'd0; din = 16'sd9; clr = 1'b1;
    for (int i = 0; i < 3; i++)
      while (exq[i].size() > 0 && exq[i][$].cyc > cyc) void'(exq[i].pop_back());
    zero_model();
    tick();
    en = 1'b0; clr = 1'b0;
    idle(4);
    send(0, 0, 4);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL clr_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL clr inst%0d #%0d: got cyc=%0d val=%0d want cyc=%0d val=%0d",
                   i, k, obs[i][k].cyc, $signed(obs[i][k].val), exq[i][k].cyc, $signed(exq[i][k].val));
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  task automatic test_reset_mid();
    send(0, 5, 10); send(0, 6, 20);
    en = 1'b1; op = 1'b0; addr = 4'd5; din = 16'sd30;
    rst_n = 1'b0;
    #1;
    checks++;
    if (oe[0] !== 1'b0 || o0 !== 24'sd0 || ovf[0] !== 1'b0 || oa[0] !== 4'd0) begin
      errors++;
      $display("FAIL rst_async: got en=%b out=%0d addr=%0d ovf=%b want 0", oe[0], o0, oa[0], ovf[0]);
    end
    for (int i = 0; i < 3; i++) exq[i].delete();
    zero_model();
    tick();
    rst_n = 1'b1; en = 1'b0;
    idle(5);
    send(0, 5, 7); send(0, 6, 1);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL rstmid_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL rstmid inst%0d #%0d: got cyc=%0d val=%0d want cyc=%0d val=%0d",
                   i, k, obs[i][k].cyc, $signed(obs[i][k].val), exq[i][k].cyc, $signed(exq[i][k].val));
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        send($urandom_range(0, 9) == 0, $urandom_range(0, 3), int'($urandom_range(0, 65535)) - 32768);
      else
        idle(1);
    end
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i].size() != exq[i].size()) begin
        errors++;
        $display("FAIL rnd_count inst%0d: got %0d want %0d", i, obs[i].size(), exq[i].size());
      end
      for (int k = 0; k < obs[i].size() && k < exq[i].size(); k++) begin
        checks++;
        if (obs[i][k] !== exq[i][k]) begin
          errors++;
          $display("FAIL rnd inst%0d #%0d: got cyc=%0d addr=%0d val=%0d ovf=%b want cyc=%0d addr=%0d val=%0d ovf=%b",
                   i, k, obs[i][k].cyc, obs[i][k].addr, $signed(obs[i][k].val), obs[i][k].ovf,
                   exq[i][k].cyc, exq[i][k].addr, $signed(exq[i][k].val), exq[i][k].ovf);
        end
      end
      obs[i].delete(); exq[i].delete();
    end
  endtask

  initial begin
    zero_model();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_forwarding();
    test_interleave();
    zero_model();
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
